fetch_ctrl: RTL and testbench

- Instruction-fetch sequencer for the MIPS IF stage; owns the program-counter register's control inputs (en, clr, d, t) and the SRAM-like instruction bus handshake.
- Arbitrates PC redirects (exception, eret, branch/jump) against sequential fetch.
- Buffers a returned instruction while the pipeline stalls; discards in-flight fetches made stale by a redirect.

---
 rtl/fetch_ctrl_if.sv | 46 ++++
 rtl/fetch_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_fetch_ctrl.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_ctrl_if.sv
// Handshake bundle between the IF-stage fetch sequencer and its neighbours (PC register, hazard unit, instruction bus, IF/ID).
// master = fetch_ctrl side; slave = the surrounding pipeline/memory side.
// Pure wiring, no state.
`timescale 1ns/1ps
interface fetch_ctrl_if #(
    parameter int WIDTH = 32
);
    // PC register control
    logic [WIDTH-1:0] pc_q;
    logic             pc_en;
    logic             pc_clr;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_t;
    // redirect sources and hazard hold
    logic             stall_i;
    logic             exc_i;
    logic             eret_i;
    logic [WIDTH-1:0] epc_i;
    logic             br_i;
    logic [WIDTH-1:0] br_tgt_i;
    // SRAM-like instruction bus
    logic             inst_req;
    logic [WIDTH-1:0] inst_addr;
    logic             inst_addr_ok;
    logic             inst_data_ok;
    logic [WIDTH-1:0] inst_rdata;
    // offer to IF/ID
    logic             if_valid;
    logic [WIDTH-1:0] if_pc;
    logic [WIDTH-1:0] if_inst;
    logic             if_adel;

    modport master (
        input  pc_q, stall_i, exc_i, eret_i, epc_i, br_i, br_tgt_i,
               inst_addr_ok, inst_data_ok, inst_rdata,
        output pc_en, pc_clr, pc_d, pc_t, inst_req, inst_addr,
               if_valid, if_pc, if_inst, if_adel
    );

    modport slave (
        output pc_q, stall_i, exc_i, eret_i, epc_i, br_i, br_tgt_i,
               inst_addr_ok, inst_data_ok, inst_rdata,
        input  pc_en, pc_clr, pc_d, pc_t, inst_req, inst_addr,
               if_valid, if_pc, if_inst, if_adel
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: drives PC register enables, instruction bus handshake, redirect arbitration (exc > eret > br).
// Latency: 2 cycles per instruction with zero-wait memory (REQ then WAIT); delivery is combinational from inst_rdata.
// Backpressure: stall_i parks a returned instruction in a one-entry hold buffer; optional ALIGN_CHECK_EN raises if_adel on misaligned PCs.
`timescale 1ns/1ps
module fetch_ctrl #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] EXC_VEC = 32'hbfc00380
) (
    input  logic         clk,
    input  logic         rst,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    localparam logic [1:0] PRI_BR   = 2'd1;
    localparam logic [1:0] PRI_ERET = 2'd2;
    localparam logic [1:0] PRI_EXC  = 2'd3;

    state_t           state_q, state_d;
    logic             rp_q, rp_d;
    logic [1:0]       rp_pri_q, rp_pri_d;
    logic [WIDTH-1:0] tgt_q, tgt_d;
    logic             discard_q, discard_d;
    logic [WIDTH-1:0] hold_pc_q, hold_pc_d;
    logic [WIDTH-1:0] hold_inst_q, hold_inst_d;
    logic             hold_adel_q, hold_adel_d;

    logic             new_vld;
    logic [1:0]       new_pri;
    logic [WIDTH-1:0] new_tgt;
    logic             take_new;
    logic             redir_any;
    logic             wait_drop;
    logic             misalign;
    logic [WIDTH-1:0] tgt_cur;

`ifdef ALIGN_CHECK_EN
    assign misalign = (bus.pc_q[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Pick the highest-priority redirect arriving this cycle.
    always_comb begin
        new_vld = 1'b0;
        new_pri = 2'd0;
        new_tgt = '0;
        if (bus.exc_i) begin
            new_vld = 1'b1;
            new_pri = PRI_EXC;
            new_tgt = EXC_VEC;
        end else if (bus.eret_i) begin
            new_vld = 1'b1;
            new_pri = PRI_ERET;
            new_tgt = bus.epc_i;
        end else if (bus.br_i) begin
            new_vld = 1'b1;
            new_pri = PRI_BR;
            new_tgt = bus.br_tgt_i;
        end
    end

    // rp_pri_q is 0 when nothing is pending, so any request wins then;
    // otherwise only an equal or higher priority one replaces the pending target.
    assign take_new  = new_vld && (new_pri >= rp_pri_q);
    assign redir_any = rp_q || new_vld;
    // pc_t reflects a same-cycle winner so a redirect taken this cycle loads the right address.
    assign tgt_cur   = take_new ? new_tgt : tgt_q;
    assign wait_drop = (state_q == S_WAIT) && bus.inst_data_ok && (discard_q || redir_any);

    assign bus.pc_d  = bus.pc_q + WIDTH'(4);
    assign bus.pc_t  = tgt_cur;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // FSM next-state: redirects win over stall release; the bus request is never withdrawn before addr_ok.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (misalign) begin
                    if (!redir_any && bus.stall_i) state_d = S_HOLD;
                    else                           state_d = S_REQ;
                end else if (bus.inst_addr_ok) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (!wait_drop && bus.stall_i) state_d = S_HOLD;
                    else                           state_d = S_REQ;
                end
            end
            S_HOLD: begin
                if (redir_any || !bus.stall_i) state_d = S_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: bus request, PC register control and the IF/ID offer.
    always_comb begin
        bus.pc_en     = 1'b0;
        bus.pc_clr    = 1'b0;
        bus.inst_req  = 1'b0;
        bus.inst_addr = '0;
        bus.if_valid  = 1'b0;
        bus.if_pc     = '0;
        bus.if_inst   = '0;
        bus.if_adel   = 1'b0;
        case (state_q)
            S_IDLE: bus.pc_clr = redir_any;
            S_REQ: begin
                if (misalign) begin
                    // No bus cycle is outstanding, so a redirect can be taken at once.
                    if (redir_any) begin
                        bus.pc_clr = 1'b1;
                    end else begin
                        bus.if_valid = 1'b1;
                        bus.if_pc    = bus.pc_q;
                        bus.if_adel  = 1'b1;
                        bus.pc_en    = !bus.stall_i;
                    end
                end else begin
                    bus.inst_req  = 1'b1;
                    bus.inst_addr = bus.pc_q;
                end
            end
            S_WAIT: begin
                if (bus.inst_data_ok) begin
                    if (discard_q || redir_any) begin
                        bus.pc_clr = 1'b1;
                    end else begin
                        bus.if_valid = 1'b1;
                        bus.if_pc    = bus.pc_q;
                        bus.if_inst  = bus.inst_rdata;
                        bus.pc_en    = !bus.stall_i;
                    end
                end
            end
            S_HOLD: begin
                if (redir_any) begin
                    bus.pc_clr = 1'b1;
                end else begin
                    bus.if_valid = 1'b1;
                    bus.if_pc    = hold_pc_q;
                    bus.if_inst  = hold_inst_q;
                    bus.if_adel  = hold_adel_q;
                    bus.pc_en    = !bus.stall_i;
                end
            end
            default: ;
        endcase
    end

    // Next values for pending redirect, stale-fetch flag and hold buffer.
    always_comb begin
        rp_d        = rp_q;
        rp_pri_d    = rp_pri_q;
        tgt_d       = tgt_q;
        discard_d   = discard_q;
        hold_pc_d   = hold_pc_q;
        hold_inst_d = hold_inst_q;
        hold_adel_d = hold_adel_q;

        if (take_new) begin
            rp_d     = 1'b1;
            rp_pri_d = new_pri;
            tgt_d    = new_tgt;
        end
        if (bus.pc_clr) begin
            rp_d     = 1'b0;
            rp_pri_d = 2'd0;
        end

        // A redirect while the address phase is open makes the coming data stale.
        if (state_q == S_REQ && !misalign && new_vld) discard_d = 1'b1;
        if (wait_drop)                                discard_d = 1'b0;

        if (state_q == S_WAIT && bus.inst_data_ok && !wait_drop && bus.stall_i) begin
            hold_pc_d   = bus.pc_q;
            hold_inst_d = bus.inst_rdata;
            hold_adel_d = 1'b0;
        end
        if (state_q == S_REQ && misalign && !redir_any && bus.stall_i) begin
            hold_pc_d   = bus.pc_q;
            hold_inst_d = '0;
            hold_adel_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rp_q        <= 1'b0;
            rp_pri_q    <= 2'd0;
            tgt_q       <= '0;
            discard_q   <= 1'b0;
            hold_pc_q   <= '0;
            hold_inst_q <= '0;
            hold_adel_q <= 1'b0;
        end else begin
            rp_q        <= rp_d;
            rp_pri_q    <= rp_pri_d;
            tgt_q       <= tgt_d;
            discard_q   <= discard_d;
            hold_pc_q   <= hold_pc_d;
            hold_inst_q <= hold_inst_d;
            hold_adel_q <= hold_adel_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with a PC register model, a pc-tagged memory model and a delivery scoreboard.
// Latency of the memory model is set per step through aok_delay / dok_delay.
// Stall and redirects are driven per cycle by the stimulus sequence.
`timescale 1ns/1ps
module tb_fetch_ctrl;
    localparam int          W    = 32;
    localparam logic [31:0] BOOT = 32'hbfc00000;
    localparam logic [31:0] EXCV = 32'hbfc00380;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if #(.WIDTH(W)) bus ();
    fetch_ctrl #(.WIDTH(W), .EXC_VEC(EXCV)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adel;
    } exp_t;
    exp_t exp_q[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic        rst_nxt  = 1'b1;
    logic [31:0] pc_m     = BOOT;
    logic        mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int          acnt = 0, dcnt = 0;
    int          aok_delay = 0, dok_delay = 0;
    logic        s_clr = 1'b0, s_en = 1'b0, s_req = 1'b0, s_aok = 1'b0, s_dok = 1'b0;
    logic [31:0] s_t = '0, s_addr = '0;

    assign bus.pc_q = pc_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // One clock: update models at negedge, drive stimulus, answer addr_ok, then sample and score.
    task automatic cyc(input logic st, input logic ex, input logic er, input logic b);
        exp_t e;
        @(negedge clk);
        if (rst) begin
            pc_m = BOOT; mem_pend = 1'b0; acnt = 0; dcnt = 0;
        end else begin
            if (s_clr)     pc_m = s_t;
            else if (s_en) pc_m = pc_m + 32'd4;
            if (s_dok)         mem_pend = 1'b0;
            else if (mem_pend) dcnt++;
            if (s_aok) begin
                mem_pend = 1'b1; mem_addr = s_addr; dcnt = 0; acnt = 0;
            end else if (s_req) begin
                acnt++;
            end
        end
        rst = rst_nxt;
        bus.stall_i      = st;
        bus.exc_i        = ex;
        bus.eret_i       = er;
        bus.br_i         = b;
        bus.inst_data_ok = mem_pend && (dcnt >= dok_delay);
        bus.inst_rdata   = mem_addr;
        #1;
        bus.inst_addr_ok = bus.inst_req && (acnt >= aok_delay);
        #1;
        s_clr = bus.pc_clr; s_en = bus.pc_en; s_t = bus.pc_t;
        s_req = bus.inst_req; s_aok = bus.inst_addr_ok; s_addr = bus.inst_addr;
        s_dok = bus.inst_data_ok;
        if (!rst) begin
            chk("pc_d", bus.pc_d, pc_m + 32'd4);
            chk1("en_clr_excl", bus.pc_en & bus.pc_clr, 1'b0);
            if (bus.if_valid && bus.pc_en) begin
                n_assert++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL sb_extra: delivery pc %h observed, none expected", bus.if_pc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("sb_pc", bus.if_pc, e.pc);
                    chk("sb_inst", bus.if_inst, e.inst);
                    chk1("sb_adel", bus.if_adel, e.adel);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.stall_i = 1'b0; bus.exc_i = 1'b0; bus.eret_i = 1'b0; bus.br_i = 1'b0;
        bus.epc_i = '0; bus.br_tgt_i = '0;
        bus.inst_addr_ok = 1'b0; bus.inst_data_ok = 1'b0; bus.inst_rdata = '0;

        // reset state
        cyc(0, 0, 0, 0);
        chk1("rst_req", bus.inst_req, 1'b0);
        chk1("rst_valid", bus.if_valid, 1'b0);
        chk1("rst_en", bus.pc_en, 1'b0);
        chk1("rst_clr", bus.pc_clr, 1'b0);
        chk1("rst_adel", bus.if_adel, 1'b0);
        chk("rst_pc_t", bus.pc_t, 32'h0);
        chk("rst_addr", bus.inst_addr, 32'h0);
        chk("rst_pc_d", bus.pc_d, BOOT + 32'd4);
        rst_nxt = 1'b0;

        // IDLE
        cyc(0, 0, 0, 0);
        chk1("idle_req", bus.inst_req, 1'b0);
        chk1("idle_clr", bus.pc_clr, 1'b0);

        // zero-wait sequential fetch: valid pulses every other cycle
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back('{pc: BOOT + 32'(4*i), inst: BOOT + 32'(4*i), adel: 1'b0});
            cyc(0, 0, 0, 0);
            chk1("seq_req", bus.inst_req, 1'b1);
            chk("seq_addr", bus.inst_addr, BOOT + 32'(4*i));
            chk1("seq_gap_valid", bus.if_valid, 1'b0);
            cyc(0, 0, 0, 0);
            chk1("seq_valid", bus.if_valid, 1'b1);
            chk1("seq_en", bus.pc_en, 1'b1);
        end

        // stall at data_ok -> HOLD for the stalled cycles
        exp_q.push_back('{pc: BOOT + 32'd12, inst: BOOT + 32'd12, adel: 1'b0});
        cyc(0, 0, 0, 0);
        chk("stall_addr", bus.inst_addr, BOOT + 32'd12);
        cyc(1, 0, 0, 0);
        chk1("stall_valid0", bus.if_valid, 1'b1);
        chk1("stall_en0", bus.pc_en, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cyc(1, 0, 0, 0);
            chk1("hold_valid", bus.if_valid, 1'b1);
            chk1("hold_req", bus.inst_req, 1'b0);
            chk1("hold_en", bus.pc_en, 1'b0);
            chk("hold_inst", bus.if_inst, BOOT + 32'd12);
        end
        cyc(0, 0, 0, 0);
        chk1("hold_rel_valid", bus.if_valid, 1'b1);
        chk1("hold_rel_en", bus.pc_en, 1'b1);

        // branch while waiting for data
        dok_delay = 1;
        bus.br_tgt_i = 32'hbfc00100;
        cyc(0, 0, 0, 0);
        chk("br_req_addr", bus.inst_addr, BOOT + 32'd16);
        cyc(0, 0, 0, 1);
        chk1("br_wait_clr", bus.pc_clr, 1'b0);
        cyc(0, 0, 0, 0);
        chk1("br_drop_valid", bus.if_valid, 1'b0);
        chk1("br_drop_clr", bus.pc_clr, 1'b1);
        chk1("br_drop_en", bus.pc_en, 1'b0);
        chk("br_drop_pc_t", bus.pc_t, 32'hbfc00100);
        exp_q.push_back('{pc: 32'hbfc00100, inst: 32'hbfc00100, adel: 1'b0});
        cyc(0, 0, 0, 0);
        chk("br_new_addr", bus.inst_addr, 32'hbfc00100);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk1("br_deliver", bus.if_valid, 1'b1);

        // exc+br together, eret next: exception keeps priority
        dok_delay = 2;
        bus.epc_i = 32'h80001000;
        cyc(0, 0, 0, 0);
        chk("pri_req_addr", bus.inst_addr, 32'hbfc00104);
        cyc(0, 1, 0, 1);
        cyc(0, 0, 1, 0);
        chk("pri_pend_t", bus.pc_t, EXCV);
        chk1("pri_pend_clr", bus.pc_clr, 1'b0);
        cyc(0, 0, 0, 0);
        chk1("pri_clr", bus.pc_clr, 1'b1);
        chk("pri_pc_t", bus.pc_t, EXCV);
        chk1("pri_valid", bus.if_valid, 1'b0);
        dok_delay = 0;
        exp_q.push_back('{pc: EXCV, inst: EXCV, adel: 1'b0});
        cyc(0, 0, 0, 0);
        chk("pri_new_addr", bus.inst_addr, EXCV);
        cyc(0, 0, 0, 0);

        // addr_ok delayed four cycles, redirect during the address phase
        aok_delay = 4;
        bus.br_tgt_i = 32'hbfc00200;
        for (int i = 0; i < 5; i++) begin
            cyc(0, 0, 0, (i == 1));
            chk1("aok_req", bus.inst_req, 1'b1);
            chk("aok_addr", bus.inst_addr, EXCV + 32'd4);
        end
        aok_delay = 0;
        cyc(0, 0, 0, 0);
        chk1("aok_drop_valid", bus.if_valid, 1'b0);
        chk1("aok_drop_clr", bus.pc_clr, 1'b1);
        chk("aok_drop_pc_t", bus.pc_t, 32'hbfc00200);
        exp_q.push_back('{pc: 32'hbfc00200, inst: 32'hbfc00200, adel: 1'b0});
        cyc(0, 0, 0, 0);
        chk("aok_new_addr", bus.inst_addr, 32'hbfc00200);
        cyc(0, 0, 0, 0);

        // exception while holding a stalled instruction
        cyc(0, 0, 0, 0);
        chk("hx_addr", bus.inst_addr, 32'hbfc00204);
        cyc(1, 0, 0, 0);
        chk1("hx_valid0", bus.if_valid, 1'b1);
        cyc(1, 1, 0, 0);
        chk1("hx_valid", bus.if_valid, 1'b0);
        chk1("hx_clr", bus.pc_clr, 1'b1);
        chk("hx_pc_t", bus.pc_t, EXCV);
        exp_q.push_back('{pc: EXCV, inst: EXCV, adel: 1'b0});
        cyc(0, 0, 0, 0);
        chk("hx_new_addr", bus.inst_addr, EXCV);
        cyc(0, 0, 0, 0);

        // reset mid-transaction, then an exception in IDLE
        cyc(0, 0, 0, 0);
        chk("rm_addr", bus.inst_addr, EXCV + 32'd4);
        rst_nxt = 1'b1;
        cyc(0, 0, 0, 0);
        chk1("rm_valid", bus.if_valid, 1'b0);
        chk1("rm_en", bus.pc_en, 1'b0);
        chk1("rm_req", bus.inst_req, 1'b0);
        rst_nxt = 1'b0;
        cyc(0, 1, 0, 0);
        chk1("idle_exc_clr", bus.pc_clr, 1'b1);
        chk("idle_exc_t", bus.pc_t, EXCV);
        chk1("idle_exc_req", bus.inst_req, 1'b0);
        exp_q.push_back('{pc: EXCV, inst: EXCV, adel: 1'b0});
        cyc(0, 0, 0, 0);
        chk("idle_new_addr", bus.inst_addr, EXCV);
        cyc(0, 0, 0, 0);

        // eret to a misaligned target
        dok_delay = 1;
        bus.epc_i = 32'hbfc00002;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 0, 0);
        chk1("mis_clr", bus.pc_clr, 1'b1);
        chk("mis_pc_t", bus.pc_t, 32'hbfc00002);
        dok_delay = 0;
`ifdef ALIGN_CHECK_EN
        exp_q.push_back('{pc: 32'hbfc00002, inst: 32'h0, adel: 1'b1});
        cyc(0, 0, 0, 0);
        chk1("adel_req", bus.inst_req, 1'b0);
        chk1("adel_valid", bus.if_valid, 1'b1);
        chk1("adel_flag", bus.if_adel, 1'b1);
        chk("adel_pc", bus.if_pc, 32'hbfc00002);
        cyc(0, 1, 0, 0);
        chk1("adel_exc_req", bus.inst_req, 1'b0);
        chk1("adel_exc_valid", bus.if_valid, 1'b0);
        chk1("adel_exc_clr", bus.pc_clr, 1'b1);
        exp_q.push_back('{pc: EXCV, inst: EXCV, adel: 1'b0});
        cyc(0, 0, 0, 0);
        chk("adel_new_addr", bus.inst_addr, EXCV);
        cyc(0, 0, 0, 0);
`else
        exp_q.push_back('{pc: 32'hbfc00002, inst: 32'hbfc00002, adel: 1'b0});
        cyc(0, 0, 0, 0);
        chk1("mis_req", bus.inst_req, 1'b1);
        chk("mis_addr", bus.inst_addr, 32'hbfc00002);
        chk1("mis_adel", bus.if_adel, 1'b0);
        cyc(0, 0, 0, 0);
        chk1("mis_valid", bus.if_valid, 1'b1);
        chk1("mis_adel_d", bus.if_adel, 1'b0);
`endif

        n_assert++;
        assert (exp_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_missing: %0d expected deliveries never observed, required 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
